// File: rtl/byte_frame_accum_if.sv
// Byte-in / frame-result-out handshake bundle for byte_frame_accum.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the byte side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_data[7:0], in_last : upstream byte and short-frame marker
//   in_ready                        : block accepts a byte this cycle
//   out_valid, out_xor[7:0], out_sum[15:0], out_count[7:0] : frame result
//   out_ready                       : downstream takes the result
//   evt                             : one-cycle frame-complete pulse
interface byte_frame_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_xor;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        evt;

  // master: the side that feeds bytes and consumes results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_xor, out_sum, out_count, evt
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_xor, out_sum, out_count, evt
  );
endinterface

// File: rtl/byte_frame_accum.sv
// Accumulates XOR, sum and count of bytes over a frame of FRAME_LEN bytes (or shorter, ended by in_last).
// Latency: result valid the cycle after the final byte is accepted; min frame period FRAME_LEN+1.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : byte_frame_accum_if.slave (byte input handshake, result output handshake, evt pulse)
module byte_frame_accum #(
  parameter int unsigned FRAME_LEN = 4  // bytes per frame, 1..255
) (
  input  logic                     clk,
  input  logic                     rst,
  byte_frame_accum_if.slave        bus
);

  localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_xor_q, acc_xor_d;
  logic [15:0] acc_sum_q, acc_sum_d;
  logic [7:0]  acc_count_q, acc_count_d;
  logic        evt_q;
  logic        in_report;
  logic        accept;

  assign in_report = (state_q == REPORT);
  assign accept    = bus.in_valid && !in_report;

  // Next-state and accumulator update
  always_comb begin
    state_d     = state_q;
    acc_xor_d   = acc_xor_q;
    acc_sum_d   = acc_sum_q;
    acc_count_d = acc_count_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (state_q == IDLE) begin
            // first byte of a frame loads rather than accumulates
            acc_xor_d   = bus.in_data;
            acc_sum_d   = {8'h00, bus.in_data};
            acc_count_d = 8'd1;
          end else begin
            acc_xor_d   = acc_xor_q ^ bus.in_data;
            acc_sum_d   = acc_sum_q + {8'h00, bus.in_data};
            acc_count_d = acc_count_q + 8'd1;
          end
          // decision uses the updated count, so FRAME_LEN=1 reports every byte
          if ((acc_count_d == FRAME_LEN_B) || bus.in_last) begin
            state_d = REPORT;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      REPORT: begin
        // in_ready is low here, so consuming a result never overlaps a new accept
        if (bus.out_ready) begin
          state_d     = IDLE;
          acc_xor_d   = 8'h00;
          acc_sum_d   = 16'h0000;
          acc_count_d = 8'h00;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_xor_q   <= 8'h00;
      acc_sum_q   <= 16'h0000;
      acc_count_q <= 8'h00;
      evt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_xor_q   <= acc_xor_d;
      acc_sum_q   <= acc_sum_d;
      acc_count_q <= acc_count_d;
      // pulse only on the transition into REPORT, not while it is held
      evt_q       <= (state_d == REPORT) && !in_report;
    end
  end

  assign bus.in_ready  = !in_report;
  assign bus.out_valid = in_report;
  assign bus.out_xor   = in_report ? acc_xor_q   : 8'h00;
  assign bus.out_sum   = in_report ? acc_sum_q   : 16'h0000;
  assign bus.out_count = in_report ? acc_count_q : 8'h00;
  assign bus.evt       = evt_q;

endmodule

// File: tb/tb_byte_frame_accum.sv
module tb_byte_frame_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte_frame_accum_if if4 ();
  byte_frame_accum_if if1 ();
  byte_frame_accum_if if255 ();

  byte_frame_accum #(.FRAME_LEN(4))   u4   (.clk(clk), .rst(rst), .bus(if4));
  byte_frame_accum #(.FRAME_LEN(1))   u1   (.clk(clk), .rst(rst), .bus(if1));
  byte_frame_accum #(.FRAME_LEN(255)) u255 (.clk(clk), .rst(rst), .bus(if255));

  // stimulus for the next frame
  logic [7:0] q_data[$];
  logic       q_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [7:0] d,
                        input logic l, input logic r);
    case (sel)
      0: begin if4.in_valid = v;   if4.in_data = d;   if4.in_last = l;   if4.out_ready = r;   end
      1: begin if1.in_valid = v;   if1.in_data = d;   if1.in_last = l;   if1.out_ready = r;   end
      default: begin if255.in_valid = v; if255.in_data = d; if255.in_last = l; if255.out_ready = r; end
    endcase
  endtask

  task automatic get(input int sel, output logic rdy, output logic ov, output logic ev,
                     output logic [7:0] x, output logic [15:0] s, output logic [7:0] c);
    case (sel)
      0: begin rdy = if4.in_ready; ov = if4.out_valid; ev = if4.evt;
               x = if4.out_xor; s = if4.out_sum; c = if4.out_count; end
      1: begin rdy = if1.in_ready; ov = if1.out_valid; ev = if1.evt;
               x = if1.out_xor; s = if1.out_sum; c = if1.out_count; end
      default: begin rdy = if255.in_ready; ov = if255.out_valid; ev = if255.evt;
               x = if255.out_xor; s = if255.out_sum; c = if255.out_count; end
    endcase
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic rdy, ov, ev;
    logic [7:0] x, c;
    logic [15:0] s;
    get(sel, rdy, ov, ev, x, s, c);
    chk({tag, ".in_ready"},  32'(rdy), 32'd1);
    chk({tag, ".out_valid"}, 32'(ov),  32'd0);
    chk({tag, ".evt"},       32'(ev),  32'd0);
    chk({tag, ".out_xor"},   32'(x),   32'd0);
    chk({tag, ".out_sum"},   32'(s),   32'd0);
    chk({tag, ".out_count"}, 32'(c),   32'd0);
  endtask

  // Sends q_data/q_last to DUT sel until the frame closes, then checks the
  // held result for hold+1 cycles (out_ready low for hold cycles) and the
  // return to idle. Call and return at a falling edge.
  task automatic run_frame(input int sel, input int flen, input int max_gap,
                           input int hold, input string tag);
    logic rdy, ov, ev;
    logic [7:0] x, c;
    logic [15:0] s;
    logic [7:0] exp_x;
    logic [15:0] exp_s;
    int exp_n;
    int gaps;

    // reference: a frame closes at FRAME_LEN bytes or at the first in_last
    exp_x = 8'h00;
    exp_s = 16'h0000;
    exp_n = 0;
    foreach (q_data[i]) begin
      exp_x ^= q_data[i];
      exp_s += 16'(q_data[i]);
      exp_n++;
      if (exp_n == flen || q_last[i]) break;
    end

    for (int i = 0; i < exp_n; i++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        check_idle(sel, {tag, ".gap"});
        set_in(sel, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      @(negedge clk);
      check_idle(sel, {tag, ".pre"});
      set_in(sel, 1'b1, q_data[i], q_last[i], 1'($urandom));
    end

    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      get(sel, rdy, ov, ev, x, s, c);
      chk({tag, ".out_valid"}, 32'(ov),  32'd1);
      chk({tag, ".evt"},       32'(ev),  32'(k == 0));
      chk({tag, ".in_ready"},  32'(rdy), 32'd0);
      chk({tag, ".out_xor"},   32'(x),   32'(exp_x));
      chk({tag, ".out_sum"},   32'(s),   32'(exp_s));
      chk({tag, ".out_count"}, 32'(c),   32'(exp_n));
      // in_valid stays high with junk: it must be ignored while reporting
      set_in(sel, 1'b1, 8'($urandom), 1'($urandom), 1'(k == hold));
    end

    @(negedge clk);
    check_idle(sel, {tag, ".after"});
    set_in(sel, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic make_random(input int max_len);
    int len;
    q_data.delete();
    q_last.delete();
    len = int'($urandom_range(max_len, 1));
    for (int i = 0; i < len; i++) begin
      q_data.push_back(8'($urandom));
      q_last.push_back(($urandom_range(5, 0) == 0) || (i == len - 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_idle(i, "reset");

    // four bytes back to back, completed by length
    q_data = '{8'h01, 8'h02, 8'h04, 8'h08};
    q_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(0, 4, 0, 0, "b2b");

    // short frame ended by in_last
    q_data = '{8'hFF, 8'hFF};
    q_last = '{1'b0, 1'b1};
    run_frame(0, 4, 0, 0, "short");

    // result held for 5 cycles
    q_data = '{8'h3C, 8'hA5, 8'h77, 8'h10};
    q_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(0, 4, 0, 5, "hold");

    // in_last on the FRAME_LEN-th byte changes nothing
    q_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    q_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_frame(0, 4, 0, 0, "last_at_len");

    // gaps between bytes
    q_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    q_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(0, 4, 3, 1, "gaps");

    // maximal frame, all 0xFF
    q_data.delete();
    q_last.delete();
    for (int i = 0; i < 255; i++) begin
      q_data.push_back(8'hFF);
      q_last.push_back(1'b0);
    end
    run_frame(2, 255, 0, 0, "len255");

    // reset after 2 of 4 bytes, with a simultaneous accept carrying in_last
    @(negedge clk);
    set_in(0, 1'b1, 8'h55, 1'b0, 1'b1);
    @(negedge clk);
    set_in(0, 1'b1, 8'h66, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 1'b1, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_idle(0, "rst_mid");
    @(negedge clk);
    check_idle(0, "rst_mid2");
    q_data = '{8'h10, 8'h10, 8'h10, 8'h10};
    q_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(0, 4, 0, 0, "post_rst");

    // reset while a result is held
    @(negedge clk);
    set_in(1, 1'b1, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_rep.out_valid", 32'(if1.out_valid), 32'd1);
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b1);
    check_idle(1, "rst_rep");
    @(negedge clk);
    check_idle(1, "rst_rep2");

    // FRAME_LEN=1: every byte is its own frame
    for (int n = 0; n < 8; n++) begin
      make_random(3);
      run_frame(1, 1, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), "len1");
    end

    // random frames, FRAME_LEN=4 (lengths beyond 4 get cut at 4)
    for (int n = 0; n < 30; n++) begin
      make_random(6);
      run_frame(0, 4, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "rand4");
    end

    // random frames, FRAME_LEN=255
    for (int n = 0; n < 3; n++) begin
      make_random(255);
      run_frame(2, 255, int'($urandom_range(1, 0)), int'($urandom_range(2, 0)), "rand255");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_frame_accum.md
BYTE_FRAME_ACCUM -- requirements
Module: byte_frame_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, bytes per frame; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream byte present.
REQ-005 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-006 SHALL have port in_data  input  8  upstream byte; ignored when in_valid=0.
REQ-007 SHALL have port in_last  input  1  marks the final byte of a short frame; sampled only on accept.
REQ-008 SHALL have port out_valid  output  1  frame result available.
REQ-009 SHALL have port out_ready  input  1  downstream takes the result.
REQ-010 SHALL have port out_xor  output  8  XOR of all bytes in the frame.
REQ-011 SHALL have port out_sum  output  16  unsigned sum of all bytes in the frame.
REQ-012 SHALL have port out_count  output  8  number of bytes in the frame.
REQ-013 SHALL have port evt  output  1  one-cycle frame-complete event pulse.

Function
REQ-014 SHALL implement states IDLE, ACCUM and REPORT; IDLE is the reset state.
REQ-015 SHALL define an accept as in_valid=1 and in_ready=1 in the same cycle.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in REPORT.
REQ-017 SHALL, on an accept in IDLE, load acc_xor=in_data, acc_sum=zero-extended in_data and acc_count=1.
REQ-018 SHALL, on an accept in ACCUM, update acc_xor^=in_data, acc_sum+=in_data and acc_count+=1.
REQ-019 SHALL, after an accept, go to REPORT next cycle if the updated acc_count==FRAME_LEN or in_last=1; otherwise go to (or stay in) ACCUM.
REQ-020 SHALL, with FRAME_LEN=1, enter REPORT after every accepted byte.
REQ-021 SHALL leave accumulators and state unchanged in cycles without an accept (bubbles).
REQ-022 SHALL give a latency of one cycle: final byte accepted in cycle T gives out_valid=1 in cycle T+1.
REQ-023 SHALL drive out_valid=1 only in REPORT, and hold out_xor, out_sum and out_count stable throughout REPORT.
REQ-024 SHALL drive out_xor, out_sum and out_count to 0 outside REPORT.
REQ-025 SHALL assert evt for exactly the first cycle of each REPORT entry, never again while REPORT is held.
REQ-026 SHALL, in REPORT with out_ready=1, return to IDLE next cycle and clear the accumulators to 0.
REQ-027 SHALL NOT accept a byte in the same cycle the result is consumed (no bypass), giving a minimum frame period of FRAME_LEN+1 cycles.
REQ-028 SHALL use a 16-bit sum, which cannot overflow for FRAME_LEN<=255 (max 0xFE01); no saturation logic is required.
REQ-029 SHALL give in_last=1 on the FRAME_LEN-th byte the same result as in_last=0.

Reset
REQ-030 SHALL, with rst=1 at a rising edge, set state=IDLE, acc_xor=0, acc_sum=0 and acc_count=0.
REQ-031 SHALL drive these values in the cycle after reset: out_valid=0, evt=0, in_ready=1, and out_xor, out_sum and out_count all 0.
REQ-032 SHALL, on reset mid-frame or during REPORT, discard the partial frame or pending result with no evt; reset takes priority over any simultaneous accept or out_ready.

Verification
REQ-033 SHALL cover: FRAME_LEN=4, bytes 0x01,0x02,0x04,0x08 back-to-back, out_ready=1 -> out_valid and evt for one cycle after the 4th accept, out_xor=0x0F, out_sum=0x000F, out_count=4, in_ready back to 1 the cycle after.
REQ-034 SHALL cover: FRAME_LEN=4, bytes 0xFF,0xFF with in_last=1 on the second -> out_xor=0x00, out_sum=0x01FE, out_count=2.
REQ-035 SHALL cover: a complete frame with out_ready=0 for 5 cycles -> out_valid high and outputs stable for 5 cycles, in_ready=0, evt high only in the first cycle, in_valid ignored.
REQ-036 SHALL cover: FRAME_LEN=255 with every byte 0xFF -> out_xor=0xFF, out_sum=0xFE01, out_count=0xFF.
REQ-037 SHALL cover: rst=1 for one cycle after 2 of 4 bytes, then 4 bytes 0x10 -> no evt from the partial frame; the result is out_count=4, out_sum=0x0040, out_xor=0x00.
REQ-038 SHALL cover: FRAME_LEN=4 with in_valid gaps of 0-3 cycles between bytes 0x01..0x04 -> the result equals the back-to-back case: out_xor=0x04, out_sum=0x000A, out_count=4.
